game_controller: RTL
====================

# game_controller

Top-level sequencer for the note-memory game. Fetches each level's note pattern from the level ROM, drives the playback block through clear/load/play, then collects and checks the player's key presses against the pattern. Tracks level, score and lives, and reports win/game-over.

## Interface

Parameters:
- NUM_LEVELS, 8, number of levels in the level ROM (2..16)
- LEVEL_W, 4, width of level_index
- INPUT_TIMEOUT, 250, idle clock cycles allowed between key presses (production value 250000000)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- start_game  in  1  single-cycle pulse; starts a game from IDLE, GAME_OVER or WIN
- level_data  in  16  pattern from level ROM; note 0 in [15:12], note 3 in [3:0]
- level_length  in  4  notes in the pattern (valid range 1..4)
- done_playback  in  1  from playback block
- key_valid  in  1  single-cycle pulse, player pressed a key
- key_note  in  4  note code of the pressed key
- level_index  out  LEVEL_W  address to level ROM
- playback_clear  out  1  one-cycle pulse; OR'd with reset into the playback block's reset
- load_level  out  1  one-cycle pulse to playback block
- start_playback  out  1  level enable to playback block
- input_enable  out  1  high while player input is accepted
- score  out  8  levels passed, saturating at 255
- lives  out  2  remaining lives
- game_over  out  1  level, high in GAME_OVER
- game_won  out  1  level, high in WIN

## Operation

- States: IDLE, FETCH, CLEAR, LOAD, PLAY, INPUT, PASS, FAIL, GAME_OVER, WIN.
- IDLE: wait for start_game. On start_game: score=0, level_index=0, lives=3, then FETCH.
- FETCH (1 cycle): latch level_data into the 16-bit expected register. Latch clamped level_length into the 3-bit remaining counter (0 becomes 1, >4 becomes 4).
- CLEAR (1 cycle): playback_clear=1.
- LOAD (1 cycle): load_level=1.
- PLAY: start_playback=1 until done_playback is sampled 1, then INPUT.
- INPUT: input_enable=1. The expected note is expected[15:12].
  - key_valid with key_note == expected note: shift expected left by 4, decrement remaining, clear the timeout counter. If remaining reaches 0, go to PASS.
  - key_valid with a mismatch: go to FAIL.
  - No key for INPUT_TIMEOUT consecutive cycles: go to FAIL.
- PASS (1 cycle): score+1, saturating. If level_index == NUM_LEVELS-1, go to WIN. Otherwise level_index+1 and go to FETCH.
- FAIL (1 cycle): behaviour per Configuration.
- GAME_OVER / WIN: hold the flag and score. start_game restarts the game exactly as from IDLE.
- key_valid outside INPUT is ignored. start_game outside IDLE/GAME_OVER/WIN is ignored.
- reset at any time: state IDLE. All outputs 0 except lives=3 (LIVES_EN) or 0 (no LIVES_EN). Expected register, remaining counter and timeout counter are cleared.

## Timing

- start_game in cycle N: FETCH in N+1, playback_clear in N+2, load_level in N+3, start_playback from N+4.
- done_playback sampled 1 in cycle M: start_playback=0 and input_enable=1 from M+1.
- The last correct key in cycle K: PASS in K+1. The next FETCH, or WIN, follows in K+2.
- Mismatch in cycle K: FAIL in K+1. Next state in K+2.
- Timeout counter counts cycles in INPUT. It is cleared on entry to INPUT and on each accepted key. Timeout fires when the count reaches INPUT_TIMEOUT-1.
- Simultaneous key_valid and timeout in the same cycle: the key wins.
- All outputs are registered except input_enable, start_playback, playback_clear and load_level, which decode directly from state.

## Configuration

- GAME_CONTROLLER_LIVES_EN defined:
  - lives starts at 3.
  - FAIL decrements lives. If the result is 0, go to GAME_OVER. Otherwise go to FETCH at the same level_index (the level is replayed).
  - The score is not changed by FAIL.
- GAME_CONTROLLER_LIVES_EN undefined:
  - lives is tied to 0.
  - FAIL always goes to GAME_OVER.

## Test plan

- Reset mid-PLAY: assert reset. Required: IDLE, start_playback=0, score=0, level_index=0, lives=3 (LIVES_EN).
- Level 0 with level_data=16'h1234, level_length=4: start_game, then done_playback, then keys 1,2,3,4. Required: PASS, score=1, level_index=1, then FETCH.
- Pattern 16'h1234, length 2: keys 1,2. Required: PASS after the 2nd key; nibbles 3 and 4 are never checked.
- Key 5 where 2 is expected:
  - With LIVES_EN: lives 3→2, same level replayed with playback_clear, load_level, start_playback.
  - Without LIVES_EN: GAME_OVER, game_over=1.
- No key for INPUT_TIMEOUT cycles in INPUT: FAIL. Also drive a key in the exact timeout cycle: the key is accepted and FAIL is not taken.
- NUM_LEVELS=2: pass both levels. Required: game_won=1, score=2. Then start_game: score=0, level_index=0, FETCH.

Source files
------------

// File: rtl/game_controller.sv
// rtl/game_controller.sv - note-memory game sequencer: level fetch, playback control, key checking, score/lives.
// Optional lives/replay behaviour is enabled by defining GAME_CONTROLLER_LIVES_EN.
module game_controller #(
    parameter int NUM_LEVELS    = 8,
    parameter int LEVEL_W       = 4,
    parameter int INPUT_TIMEOUT = 250
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_game,
    input  logic [15:0]        level_data,
    input  logic [3:0]         level_length,
    input  logic               done_playback,
    input  logic               key_valid,
    input  logic [3:0]         key_note,
    output logic [LEVEL_W-1:0] level_index,
    output logic               playback_clear,
    output logic               load_level,
    output logic               start_playback,
    output logic               input_enable,
    output logic [7:0]         score,
    output logic [1:0]         lives,
    output logic               game_over,
    output logic               game_won
);

    localparam logic [3:0] IDLE      = 4'd0;
    localparam logic [3:0] FETCH     = 4'd1;
    localparam logic [3:0] CLEAR     = 4'd2;
    localparam logic [3:0] LOAD      = 4'd3;
    localparam logic [3:0] PLAY      = 4'd4;
    localparam logic [3:0] INPUT     = 4'd5;
    localparam logic [3:0] PASS      = 4'd6;
    localparam logic [3:0] FAIL      = 4'd7;
    localparam logic [3:0] GAME_OVER = 4'd8;
    localparam logic [3:0] WIN       = 4'd9;

    localparam int TIMER_W = $clog2(INPUT_TIMEOUT + 1);
    localparam logic [LEVEL_W-1:0] LAST_LEVEL = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(INPUT_TIMEOUT - 1);

    logic [3:0]         state;
    logic [3:0]         next_state;
    logic [15:0]        expected;
    logic [2:0]         remaining;
    logic [TIMER_W-1:0] timer;
    logic               key_hit;
    logic               timeout_hit;
    logic               restart;

    assign key_hit     = key_valid && (key_note == expected[15:12]);
    assign timeout_hit = (timer == TIMER_LAST);
    assign restart     = start_game && ((state == IDLE) || (state == GAME_OVER) || (state == WIN));

    assign playback_clear = (state == CLEAR);
    assign load_level     = (state == LOAD);
    assign start_playback = (state == PLAY);
    assign input_enable   = (state == INPUT);

    always_comb begin
        next_state = state;
        case (state)
            IDLE, GAME_OVER, WIN: if (start_game) next_state = FETCH;
            FETCH:                next_state = CLEAR;
            CLEAR:                next_state = LOAD;
            LOAD:                 next_state = PLAY;
            PLAY:                 if (done_playback) next_state = INPUT;
            INPUT: begin
                // A key in the timeout cycle takes priority over the timeout.
                if (key_valid) begin
                    if (!key_hit)              next_state = FAIL;
                    else if (remaining == 3'd1) next_state = PASS;
                end else if (timeout_hit) begin
                    next_state = FAIL;
                end
            end
            PASS:                 next_state = (level_index == LAST_LEVEL) ? WIN : FETCH;
`ifdef GAME_CONTROLLER_LIVES_EN
            FAIL:                 next_state = (lives == 2'd1) ? GAME_OVER : FETCH;
`else
            FAIL:                 next_state = GAME_OVER;
`endif
            default:              next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            expected    <= 16'd0;
            remaining   <= 3'd0;
            timer       <= '0;
            score       <= 8'd0;
            level_index <= '0;
            game_over   <= 1'b0;
            game_won    <= 1'b0;
        end else begin
            state     <= next_state;
            game_over <= (next_state == GAME_OVER);
            game_won  <= (next_state == WIN);
            if (state != INPUT) timer <= '0;
            if (restart) begin
                score       <= 8'd0;
                level_index <= '0;
            end
            case (state)
                FETCH: begin
                    expected <= level_data;
                    if (level_length == 4'd0)     remaining <= 3'd1;
                    else if (level_length > 4'd4) remaining <= 3'd4;
                    else                           remaining <= level_length[2:0];
                end
                INPUT: begin
                    if (key_hit) begin
                        expected  <= {expected[11:0], 4'd0};
                        remaining <= remaining - 3'd1;
                        timer     <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                PASS: begin
                    if (score != 8'hFF) score <= score + 8'd1;
                    if (level_index != LAST_LEVEL) level_index <= level_index + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef GAME_CONTROLLER_LIVES_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                lives <= 2'd3;
        else if (restart)         lives <= 2'd3;
        else if (state == FAIL)   lives <= lives - 2'd1;
    end
`else
    assign lives = 2'd0;
`endif

endmodule
